// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the core/DMA memory arbiter.
package riscv_mem_pkg;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        DMA_BURST = 1'b1
    } arb_state_t;

    typedef enum logic [0:0] {
        CORE = 1'b0,
        DMA  = 1'b1
    } owner_t;

    localparam int MAX_BURST_DEFAULT = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the port that did not own the memory last wins.
module rr_arb2
    import riscv_mem_pkg::*;
(
    input  logic       core_req_i,
    input  logic       dma_req_i,
    input  owner_t     last_owner_i,
    output logic [1:0] gnt_o          // bit 0 = core, bit 1 = DMA
);

    // One-hot grant selection
    always_comb begin
        gnt_o = 2'b00;
        if (core_req_i && dma_req_i) begin
            gnt_o = (last_owner_i == DMA) ? 2'b01 : 2'b10;
        end else if (core_req_i) begin
            gnt_o = 2'b01;
        end else if (dma_req_i) begin
            gnt_o = 2'b10;
        end else begin
            gnt_o = 2'b00;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the core and a DMA loader, with bounded
// DMA bursts and round-robin tie breaking.
module mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEFAULT,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_core_req,
    input  logic              i_core_we,
    input  logic [ADDR_W-1:0] i_core_addr,
    input  logic [DATA_W-1:0] i_core_wdata,
    output logic              o_core_gnt,
    output logic              o_core_rvalid,
    output logic [DATA_W-1:0] o_core_rdata,
    input  logic              i_dma_req,
    input  logic              i_dma_we,
    input  logic              i_dma_last,
    input  logic [ADDR_W-1:0] i_dma_addr,
    input  logic [DATA_W-1:0] i_dma_wdata,
    output logic              o_dma_gnt,
    output logic              o_dma_rvalid,
    output logic [DATA_W-1:0] o_dma_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BEAT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] BEAT_MAX = CNT_W'(MAX_BURST);

    arb_state_t       state_q, state_d;
    owner_t           last_owner_q, last_owner_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic             core_rvalid_q, core_rvalid_d;
    logic             dma_rvalid_q, dma_rvalid_d;
    logic [1:0]       rr_gnt_s;
    logic             core_gnt_s, dma_gnt_s;

    rr_arb2 u_rr_arb2 (
        .core_req_i   (i_core_req),
        .dma_req_i    (i_dma_req),
        .last_owner_i (last_owner_q),
        .gnt_o        (rr_gnt_s)
    );

    // Grant decode: an active burst locks out the core while DMA keeps requesting
    always_comb begin
        core_gnt_s = 1'b0;
        dma_gnt_s  = 1'b0;
        if (i_rst) begin
            core_gnt_s = 1'b0;
            dma_gnt_s  = 1'b0;
        end else if (state_q == DMA_BURST && i_dma_req) begin
            dma_gnt_s = 1'b1;
        end else begin
            core_gnt_s = rr_gnt_s[0];
            dma_gnt_s  = rr_gnt_s[1];
        end
    end

    // Next state, owner tracking, beat counting and read-valid generation
    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        last_owner_d  = last_owner_q;
        core_rvalid_d = core_gnt_s & ~i_core_we;
        dma_rvalid_d  = dma_gnt_s & ~i_dma_we;

        if (core_gnt_s) begin
            last_owner_d = CORE;
        end else if (dma_gnt_s) begin
            last_owner_d = DMA;
        end else begin
            last_owner_d = last_owner_q;
        end

        case (state_q)
            IDLE: begin
                if (dma_gnt_s && !i_dma_last) begin
                    state_d = DMA_BURST;
                    beat_d  = BEAT_ONE;
                end else begin
                    state_d = IDLE;
                    beat_d  = '0;
                end
            end
            DMA_BURST: begin
                // The beat that reaches MAX_BURST releases the bus just like i_dma_last
                if (dma_gnt_s && !i_dma_last && (beat_q + BEAT_ONE) != BEAT_MAX) begin
                    state_d = DMA_BURST;
                    beat_d  = beat_q + BEAT_ONE;
                end else begin
                    state_d = IDLE;
                    beat_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            last_owner_q  <= DMA;
            beat_q        <= '0;
            core_rvalid_q <= 1'b0;
            dma_rvalid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_owner_q  <= last_owner_d;
            beat_q        <= beat_d;
            core_rvalid_q <= core_rvalid_d;
            dma_rvalid_q  <= dma_rvalid_d;
        end
    end

    // Memory port mux, zeroed when nobody holds a grant
    always_comb begin
        o_mem_en    = core_gnt_s | dma_gnt_s;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (core_gnt_s) begin
            o_mem_we    = i_core_we;
            o_mem_addr  = i_core_addr;
            o_mem_wdata = i_core_wdata;
        end else if (dma_gnt_s) begin
            o_mem_we    = i_dma_we;
            o_mem_addr  = i_dma_addr;
            o_mem_wdata = i_dma_wdata;
        end else begin
            o_mem_we    = 1'b0;
            o_mem_addr  = '0;
            o_mem_wdata = '0;
        end
    end

    assign o_core_gnt    = core_gnt_s;
    assign o_dma_gnt     = dma_gnt_s;
    assign o_core_rvalid = core_rvalid_q;
    assign o_dma_rvalid  = dma_rvalid_q;
    assign o_core_rdata  = i_mem_rdata;
    assign o_dma_rdata   = i_mem_rdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have exactly one clock, i_clk, and one reset, i_rst, which is synchronous and active-high; no other clock or reset SHALL exist.
REQ-002 Parameter MAX_BURST, default 8 (range 2..64), SHALL set the maximum number of consecutive DMA beats granted before a forced release.
REQ-003 Parameters ADDR_W, default 32, and DATA_W, default 32, SHALL set the address width and the data width.
REQ-004 Ports SHALL be, in this order:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_core_req  in  1  core memory request (multicycle control FSM)
- i_core_we  in  1  core write enable
- i_core_addr  in  ADDR_W  core address
- i_core_wdata  in  DATA_W  core write data
- o_core_gnt  out  1  core beat accepted this cycle
- o_core_rvalid  out  1  core read data valid
- o_core_rdata  out  DATA_W  core read data
- i_dma_req  in  1  loader/DMA request
- i_dma_we  in  1  DMA write enable
- i_dma_last  in  1  final beat of the DMA burst
- i_dma_addr  in  ADDR_W  DMA address
- i_dma_wdata  in  DATA_W  DMA write data
- o_dma_gnt  out  1  DMA beat accepted this cycle
- o_dma_rvalid  out  1  DMA read data valid
- o_dma_rdata  out  DATA_W  DMA read data
- o_mem_en  out  1  memory access strobe
- o_mem_we  out  1  memory write strobe
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  DATA_W  memory write data
- i_mem_rdata  in  DATA_W  memory read data, one-cycle latency

Function
REQ-005 At most one of o_core_gnt and o_dma_gnt SHALL be high in any cycle; a grant SHALL be combinational from the current request and the current state.
REQ-006 o_mem_en SHALL equal (o_core_gnt | o_dma_gnt); o_mem_we, o_mem_addr and o_mem_wdata SHALL be the granted port's signals; when there is no grant they SHALL be 0.
REQ-007 The state machine SHALL have two states, IDLE and DMA_BURST, plus a last_owner register (CORE or DMA) and a beat counter of width clog2(MAX_BURST+1).
REQ-008 In IDLE, when exactly one port requests, that port SHALL be granted.
REQ-009 In IDLE, when both ports request, the port that is not last_owner SHALL be granted (round-robin).
REQ-010 last_owner SHALL update to the granted port on every grant.
REQ-011 In IDLE, a DMA grant with i_dma_last=0 SHALL move the state to DMA_BURST with beat count 1; a DMA grant with i_dma_last=1 SHALL keep the state in IDLE.
REQ-012 In DMA_BURST with i_dma_req=1, DMA SHALL be granted unconditionally, the core SHALL be held off, and the beat count SHALL increment.
REQ-013 In DMA_BURST, the state SHALL return to IDLE after any granted beat with i_dma_last=1, or after the granted beat that brings the count to MAX_BURST (forced release).
REQ-014 In DMA_BURST with i_dma_req=0, the cycle SHALL be arbitrated as IDLE (the core may be granted in that same cycle), and the state SHALL return to IDLE.
REQ-015 After a forced release, the core SHALL win the next simultaneous request because last_owner=DMA.
REQ-016 o_X_rvalid SHALL be registered high exactly one cycle after a granted read (we=0) on port X.
REQ-017 o_core_rdata and o_dma_rdata SHALL both carry i_mem_rdata unmodified; only rvalid SHALL qualify them.
REQ-018 Granted writes SHALL produce no rvalid.
REQ-019 A requester that is not granted SHALL hold its request and signals stable until granted; the arbiter SHALL NOT buffer requests.

Reset
REQ-020 On i_rst=1 at a clock edge: state=IDLE, last_owner=DMA, beat count=0, o_core_rvalid=0, o_dma_rvalid=0.
REQ-021 While i_rst=1, all grants and o_mem_en SHALL be 0.
REQ-022 A reset mid-burst SHALL discard the burst; any rvalid owed for a read granted in the reset cycle SHALL be suppressed.

Structure
REQ-023 Package riscv_mem_pkg SHALL hold the arb_state_t enum (IDLE, DMA_BURST), the owner_t enum (CORE, DMA) and the MAX_BURST default constant.
REQ-024 The two-way round-robin pick SHALL be the sub-module rr_arb2 (inputs: two requests and last_owner; outputs: one-hot grant); all state SHALL reside in mem_arbiter.

Verification
REQ-025 Reset, then core read at 0x100 with no DMA -> o_core_gnt same cycle; o_mem_addr=0x100; o_core_rvalid the next cycle with o_core_rdata = i_mem_rdata.
REQ-026 Both request in the first cycle after reset -> core granted first; both hold the next cycle -> DMA granted; the pattern alternates.
REQ-027 DMA 4-beat write burst (last on beat 4) with the core requesting throughout -> DMA granted 4 consecutive cycles, then the core is granted in cycle 5.
REQ-028 MAX_BURST=8, DMA 12-beat burst with the core waiting -> DMA holds for 8 beats, the core gets 1 beat, then DMA resumes.
REQ-029 DMA drops i_dma_req mid-burst while the core requests -> the core is granted in that same cycle and the state is IDLE.
REQ-030 i_rst asserted in the cycle of a DMA read grant during a burst -> no o_dma_rvalid the next cycle, state IDLE, and the core wins the next tie.
